// File: rtl/byte_word_assembler.sv
// Packs pairs of bytes (low first) from a valid/ready stream into a held 16-bit word.
// Supports downstream stall, timeout discard of half-received words, and debug counters.
module byte_word_assembler #(
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [7:0]       i_byte,
    input  logic             i_byte_valid,
    output logic             o_byte_ready,
    input  logic             i_hold,
    output logic [15:0]      o_data,
    output logic             o_data_valid,
    output logic [CNT_W-1:0] o_word_count,
    output logic             o_err,
    output logic [CNT_W-1:0] o_err_count
);

    typedef enum logic [0:0] {
        S_LOW  = 1'b0,
        S_HIGH = 1'b1
    } state_t;

    localparam logic [7:0]       TIMEOUT_C = 8'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_ONE_C = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX_C = {CNT_W{1'b1}};

    state_t           state_r, state_s;
    logic [7:0]       low_r, low_s;
    logic [7:0]       timer_r, timer_s;
    logic [7:0]       timer_inc_s;
    logic [15:0]      data_r, data_s;
    logic             dv_r, dv_s;
    logic             err_r, err_s;
    logic [CNT_W-1:0] wc_r, wc_s;
    logic [CNT_W-1:0] ec_r, ec_s;
    logic             accept_s;

    assign o_byte_ready = ~i_hold;
    assign accept_s     = i_byte_valid & ~i_hold;
    assign timer_inc_s  = timer_r + 8'd1;

    assign o_data       = data_r;
    assign o_data_valid = dv_r;
    assign o_word_count = wc_r;
    assign o_err        = err_r;
    assign o_err_count  = ec_r;

    // Next-state and next-output logic; an accepted high byte takes priority over timeout expiry.
    always_comb begin
        state_s = state_r;
        low_s   = low_r;
        timer_s = timer_r;
        data_s  = data_r;
        dv_s    = 1'b0;
        err_s   = 1'b0;
        wc_s    = wc_r;
        ec_s    = ec_r;
        case (state_r)
            S_LOW: begin
                if (accept_s) begin
                    low_s   = i_byte;
                    timer_s = 8'd0;
                    state_s = S_HIGH;
                end else begin
                    state_s = S_LOW;
                end
            end
            S_HIGH: begin
                if (accept_s) begin
                    data_s  = {i_byte, low_r};
                    dv_s    = 1'b1;
                    wc_s    = wc_r + CNT_ONE_C;
                    state_s = S_LOW;
                end else if (!i_hold) begin
                    if (timer_inc_s == TIMEOUT_C) begin
                        low_s   = 8'd0;
                        err_s   = 1'b1;
                        ec_s    = (ec_r == CNT_MAX_C) ? ec_r : (ec_r + CNT_ONE_C);
                        timer_s = 8'd0;
                        state_s = S_LOW;
                    end else begin
                        timer_s = timer_inc_s;
                    end
                end else begin
                    timer_s = timer_r;
                end
            end
            default: begin
                state_s = S_LOW;
                timer_s = 8'd0;
            end
        endcase
    end

    // State and registered outputs; synchronous reset overrides any acceptance.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r <= S_LOW;
            low_r   <= 8'd0;
            timer_r <= 8'd0;
            data_r  <= 16'h0000;
            dv_r    <= 1'b0;
            err_r   <= 1'b0;
            wc_r    <= {CNT_W{1'b0}};
            ec_r    <= {CNT_W{1'b0}};
        end else begin
            state_r <= state_s;
            low_r   <= low_s;
            timer_r <= timer_s;
            data_r  <= data_s;
            dv_r    <= dv_s;
            err_r   <= err_s;
            wc_r    <= wc_s;
            ec_r    <= ec_s;
        end
    end

endmodule
